// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, control codes, arbiter FSM states and op legality helper.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_CTRL_W = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_NOT = 4'b1001;
    localparam logic [3:0] ALU_DIV = 4'b1010;
    localparam logic [3:0] ALU_MOV = 4'b1011;
    localparam logic [3:0] ALU_MOD = 4'b1101;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

    // True for codes the ALU does not implement and for divide/modulo by zero.
    function automatic logic op_flagged(input logic [3:0] op, input logic b_zero);
        logic flag;
        flag = 1'b0;
        case (op)
            4'b1100, 4'b1110, 4'b1111: flag = 1'b1;
            ALU_DIV, ALU_MOD:          flag = b_zero;
            default:                   flag = 1'b0;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters plus the ALU connection of the arbiter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and payload stable until then.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              rq0_valid, rq1_valid;
    logic              rq0_ready, rq1_ready;
    logic [DATA_W-1:0] rq0_a, rq0_b, rq1_a, rq1_b;
    logic [CTRL_W-1:0] rq0_op, rq1_op;
    logic              rs0_valid, rs1_valid;
    logic              rs0_ready, rs1_ready;
    logic [DATA_W-1:0] rs0_result, rs1_result;
    logic              rs0_zero, rs1_zero;
    logic              rs0_err, rs1_err;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    modport master (
        output rq0_valid, rq1_valid, rq0_a, rq0_b, rq1_a, rq1_b, rq0_op, rq1_op,
        output rs0_ready, rs1_ready, alu_result, alu_zero,
        input  rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs0_result, rs1_result,
        input  rs0_zero, rs1_zero, rs0_err, rs1_err, alu_a, alu_b, alu_control
    );

    modport slave (
        input  rq0_valid, rq1_valid, rq0_a, rq0_b, rq1_a, rq1_b, rq0_op, rq1_op,
        input  rs0_ready, rs1_ready, alu_result, alu_zero,
        output rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs0_result, rs1_result,
        output rs0_zero, rs1_zero, rs0_err, rs1_err, alu_a, alu_b, alu_control
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    assign grant_valid = valid0 | valid1;
    assign grant       = valid1 & (~valid0 | ~last_grant);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional op checking in EXEC is built when ALU_ARB_OPCHK_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output arb_state_e   dbg_state
);
    arb_state_e        state, next_state;
    logic              last_grant, owner;
    logic              gnt_valid, gnt;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [CTRL_W-1:0] alu_control_q;
    logic              rs0_valid_q, rs1_valid_q;
    logic [DATA_W-1:0] rs0_result_q, rs1_result_q;
    logic              rs0_zero_q, rs1_zero_q;
    logic [DATA_W-1:0] cap_result;
    logic              cap_zero;

    rr_arb2 u_rr_arb2 (
        .valid0      (bus.rq0_valid),
        .valid1      (bus.rq1_valid),
        .last_grant  (last_grant),
        .grant_valid (gnt_valid),
        .grant       (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // rq_ready depends only on state and rq_valid, so rs_ready never reaches it combinationally.
    always_comb begin
        next_state    = state;
        bus.rq0_ready = 1'b0;
        bus.rq1_ready = 1'b0;
        case (state)
            IDLE: if (gnt_valid) begin
                next_state    = EXEC;
                bus.rq0_ready = ~gnt;
                bus.rq1_ready = gnt;
            end
            EXEC: next_state = RESP;
            RESP: if (owner ? bus.rs1_ready : bus.rs0_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef ALU_ARB_OPCHK_EN
    logic flag, rs0_err_q, rs1_err_q;
    always_comb begin
        flag       = op_flagged(alu_control_q, alu_b_q == '0);
        cap_result = flag ? '0 : bus.alu_result;
        cap_zero   = flag | bus.alu_zero;
    end
    assign bus.rs0_err = rs0_err_q;
    assign bus.rs1_err = rs1_err_q;
`else
    assign cap_result  = bus.alu_result;
    assign cap_zero    = bus.alu_zero;
    assign bus.rs0_err = 1'b0;
    assign bus.rs1_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            rs0_valid_q   <= 1'b0;
            rs1_valid_q   <= 1'b0;
            rs0_result_q  <= '0;
            rs1_result_q  <= '0;
            rs0_zero_q    <= 1'b0;
            rs1_zero_q    <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            rs0_err_q     <= 1'b0;
            rs1_err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    owner         <= gnt;
                    alu_a_q       <= gnt ? bus.rq1_a  : bus.rq0_a;
                    alu_b_q       <= gnt ? bus.rq1_b  : bus.rq0_b;
                    alu_control_q <= gnt ? bus.rq1_op : bus.rq0_op;
                end
                EXEC: if (owner) begin
                    rs1_valid_q  <= 1'b1;
                    rs1_result_q <= cap_result;
                    rs1_zero_q   <= cap_zero;
`ifdef ALU_ARB_OPCHK_EN
                    rs1_err_q    <= flag;
`endif
                end else begin
                    rs0_valid_q  <= 1'b1;
                    rs0_result_q <= cap_result;
                    rs0_zero_q   <= cap_zero;
`ifdef ALU_ARB_OPCHK_EN
                    rs0_err_q    <= flag;
`endif
                end
                RESP: if (next_state == IDLE) begin
                    last_grant <= owner;
                    if (owner) rs1_valid_q <= 1'b0;
                    else       rs0_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_control = alu_control_q;
    assign bus.rs0_valid   = rs0_valid_q;
    assign bus.rs1_valid   = rs1_valid_q;
    assign bus.rs0_result  = rs0_result_q;
    assign bus.rs1_result  = rs1_result_q;
    assign bus.rs0_zero    = rs0_zero_q;
    assign bus.rs1_zero    = rs1_zero_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected grants/responses, negedge monitor pops and compares.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(W), .CTRL_W(4)) bus ();
    arb_state_e dbg_state;

    alu_arbiter #(.DATA_W(W), .CTRL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Reference ALU the arbiter drives.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_control)
            ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
            ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_SLT: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            ALU_SLL: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            ALU_SRL: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            ALU_MUL: bus.alu_result = bus.alu_a * bus.alu_b;
            ALU_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
            ALU_NOT: bus.alu_result = ~bus.alu_a;
            ALU_MOV: bus.alu_result = bus.alu_b;
            ALU_DIV: bus.alu_result = (bus.alu_b == '0) ? '1 : bus.alu_a / bus.alu_b;
            ALU_MOD: bus.alu_result = (bus.alu_b == '0) ? '1 : bus.alu_a % bus.alu_b;
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q0[$];   // {err, zero, result}
    logic [W+1:0] exp_q1[$];
    int           grant_q[$];

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] rsp(input logic err, input logic zero, input logic [W-1:0] res);
        return {err, zero, res};
    endfunction

    // Monitor: grants and responses are checked against the expected queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((bus.rq0_valid && bus.rq0_ready) || (bus.rq1_valid && bus.rq1_ready)) begin
                if (grant_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected actual=port%0d required=none", bus.rq1_ready);
                end else begin
                    check("grant_port", {33'd0, bus.rq1_ready}, grant_q.pop_front());
                end
            end
            if (bus.rs0_valid && bus.rs0_ready) begin
                if (exp_q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rs0_unexpected actual=%h required=none", bus.rs0_result);
                end else begin
                    check("rs0_resp", {bus.rs0_err, bus.rs0_zero, bus.rs0_result}, exp_q0.pop_front());
                end
            end
            if (bus.rs1_valid && bus.rs1_ready) begin
                if (exp_q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rs1_unexpected actual=%h required=none", bus.rs1_result);
                end else begin
                    check("rs1_resp", {bus.rs1_err, bus.rs1_zero, bus.rs1_result}, exp_q1.pop_front());
                end
            end
        end
    end

    task automatic send(input int port, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        bit done;
        done = 1'b0;
        if (port == 0) begin
            bus.rq0_a = a; bus.rq0_b = b; bus.rq0_op = op; bus.rq0_valid = 1'b1;
        end else begin
            bus.rq1_a = a; bus.rq1_b = b; bus.rq1_op = op; bus.rq1_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((port == 0) ? bus.rq0_ready : bus.rq1_ready) done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout port=%0d actual=no_ready required=ready", port);
        end
        @(posedge clk);
        #1;
        if (port == 0) bus.rq0_valid = 1'b0;
        else           bus.rq1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (exp_q0.size() + exp_q1.size() + grant_q.size()) != 0; i++)
            @(posedge clk);
        if ((exp_q0.size() + exp_q1.size() + grant_q.size()) != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q0.size() + exp_q1.size() + grant_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q0.delete(); exp_q1.delete(); grant_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0;
        bus.rq0_a = '0; bus.rq0_b = '0; bus.rq0_op = '0;
        bus.rq1_a = '0; bus.rq1_b = '0; bus.rq1_op = '0;
        bus.rs0_ready = 1'b1; bus.rs1_ready = 1'b1;
        #1;
        check("reset_handshake", {30'd0, bus.rq0_ready, bus.rq1_ready, bus.rs0_valid, bus.rs1_valid}, '0);
        check("reset_rs0", {bus.rs0_err, bus.rs0_zero, bus.rs0_result}, '0);
        check("reset_rs1", {bus.rs1_err, bus.rs1_zero, bus.rs1_result}, '0);
        check("reset_alu_a", {2'b0, bus.alu_a}, '0);
        check("reset_alu_b", {2'b0, bus.alu_b}, '0);
        check("reset_alu_ctl", {30'd0, bus.alu_control}, '0);
        check("reset_state", {32'd0, dbg_state}, {32'd0, IDLE});
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ADD on port 0 with latency check.
        grant_q.push_back(0);
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'd12));
        send(0, 32'd5, 32'd7, ALU_ADD);
        check("add_exec_no_valid", {33'd0, bus.rs0_valid}, '0);
        @(posedge clk); #1;
        check("add_resp_valid", {33'd0, bus.rs0_valid}, 34'd1);
        wait_drain();

        // SUB to zero on port 1.
        grant_q.push_back(1);
        exp_q1.push_back(rsp(1'b0, 1'b1, 32'd0));
        send(1, 32'd9, 32'd9, ALU_SUB);
        wait_drain();

        // Contention straight out of reset: port 0 first.
        do_reset();
        grant_q.push_back(0); grant_q.push_back(1);
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'hFF));
        exp_q1.push_back(rsp(1'b0, 1'b1, 32'h00));
        fork
            send(0, 32'hF0, 32'h0F, ALU_XOR);
            send(1, 32'hF0, 32'h0F, ALU_AND);
        join
        wait_drain();

        // Four back-to-back requests alternate 0,1,0,1.
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'd3));
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'd7));
        exp_q1.push_back(rsp(1'b0, 1'b0, 32'hA5));
        exp_q1.push_back(rsp(1'b0, 1'b0, 32'd16));
        fork
            begin send(0, 32'd1, 32'd2, ALU_ADD); send(0, 32'd10, 32'd3, ALU_SUB); end
            begin send(1, 32'hA0, 32'h05, ALU_OR); send(1, 32'd1, 32'd4, ALU_SLL); end
        join
        wait_drain();

        // Backpressure on port 0 while port 1 waits.
        bus.rs0_ready = 1'b0;
        grant_q.push_back(0);
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'd42));
        send(0, 32'd6, 32'd7, ALU_MUL);
        for (int i = 0; i < 10 && !bus.rs0_valid; i++) @(negedge clk);
        bus.rq1_a = 32'hFF; bus.rq1_b = 32'h0F; bus.rq1_op = ALU_AND; bus.rq1_valid = 1'b1;
        grant_q.push_back(1);
        exp_q1.push_back(rsp(1'b0, 1'b0, 32'h0F));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result", {bus.rs0_valid, bus.rs0_zero, bus.rs0_result}, {1'b1, 1'b0, 32'd42});
            check("bp_state", {32'd0, dbg_state}, {32'd0, RESP});
            check("bp_rq1_ready", {33'd0, bus.rq1_ready}, '0);
        end
        @(posedge clk); #1;
        bus.rs0_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rq1_accept", {33'd0, bus.rq1_ready}, 34'd1);
        @(posedge clk); #1;
        bus.rq1_valid = 1'b0;
        wait_drain();

        // Asynchronous reset during EXEC drops the operation.
        grant_q.push_back(0);
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'd7));
        send(0, 32'd3, 32'd4, ALU_ADD);
        check("midop_in_exec", {32'd0, dbg_state}, {32'd0, EXEC});
        rst_n = 1'b0;
        #1;
        check("midop_alu_a", {2'b0, bus.alu_a}, '0);
        check("midop_alu_ctl", {30'd0, bus.alu_control}, '0);
        check("midop_outputs", {30'd0, bus.rs0_valid, bus.rs1_valid, bus.rq0_ready, bus.rq1_ready}, '0);
        check("midop_state", {32'd0, dbg_state}, {32'd0, IDLE});
        exp_q0.delete(); exp_q1.delete(); grant_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant_q.push_back(0); grant_q.push_back(1);
        exp_q0.push_back(rsp(1'b0, 1'b0, 32'h3C));
        exp_q1.push_back(rsp(1'b0, 1'b0, 32'd2));
        fork
            send(0, 32'h33, 32'h0F, ALU_XOR);
            send(1, 32'd1, 32'd1, ALU_ADD);
        join
        wait_drain();

        // Op checking.
`ifdef ALU_ARB_OPCHK_EN
        grant_q.push_back(0); exp_q0.push_back(rsp(1'b1, 1'b1, 32'd0));
        send(0, 32'd10, 32'd0, ALU_DIV);
        wait_drain();
        grant_q.push_back(1); exp_q1.push_back(rsp(1'b1, 1'b1, 32'd0));
        send(1, 32'd1, 32'd1, 4'b1111);
        wait_drain();
`else
        grant_q.push_back(0); exp_q0.push_back(rsp(1'b0, 1'b0, 32'hFFFF_FFFF));
        send(0, 32'd10, 32'd0, ALU_DIV);
        wait_drain();
`endif
        grant_q.push_back(1); exp_q1.push_back(rsp(1'b0, 1'b0, 32'd3));
        send(1, 32'd10, 32'd3, ALU_DIV);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
